// File: rtl/rvc_lsu_5pl.sv
// Load/store unit: turns one MEM-stage load/store into one or two word-aligned memory beats,
// then merges, aligns and extends the returned load data into a single response pulse.
module rvc_lsu_5pl #(
  parameter logic [31:0] ADDR_LO     = 32'h0000_1000,
  parameter logic [31:0] ADDR_HI     = 32'h0000_1FFF,
  parameter bit          SPLIT_EN    = 1'b1,
  parameter int unsigned RSP_TIMEOUT = 16
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        LsuReqValid,
  output logic        LsuReqReady,
  input  logic        LsuReqWr,
  input  logic [2:0]  LsuReqFunct3,
  input  logic [31:0] LsuReqAddr,
  input  logic [31:0] LsuReqWrData,
  output logic        LsuRspValid,
  output logic        LsuRspErr,
  output logic [31:0] LsuRspData,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic [31:0] MemReqAddr,
  output logic        MemReqWrEn,
  output logic [3:0]  MemReqByteEn,
  output logic [31:0] MemReqWrData,
  input  logic        MemRspValid,
  input  logic [31:0] MemRspData
);

  localparam int unsigned   CW       = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RSP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_wr;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;
  logic          r_split;
  logic [3:0]    r_be_hi;
  logic [31:0]   r_wd_hi;
  logic [31:0]   r_word;
  logic [63:0]   r_buf;
  logic [CW-1:0] r_cnt;

  logic [3:0]  w_lanes;
  logic [2:0]  w_nb;
  logic [7:0]  w_mask8;
  logic [32:0] w_last;
  logic [63:0] w_wd64;
  logic        w_err;
  logic [63:0] w_buf_nxt;
  logic [31:0] w_raw;
  logic [31:0] w_ld_data;

  function automatic logic [31:0] ld_extend(input logic [31:0] raw, input logic [2:0] f3);
    logic [31:0] res;
    case (f3[1:0])
      2'd0:    res = {{24{~f3[2] & raw[7]}}, raw[7:0]};
      2'd1:    res = {{16{~f3[2] & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Decode the incoming request: lane mask over two words, last byte, legality.
  always_comb begin
    w_lanes = 4'b1111;
    w_nb    = 3'd4;
    case (LsuReqFunct3[1:0])
      2'd0:    begin w_lanes = 4'b0001; w_nb = 3'd1; end
      2'd1:    begin w_lanes = 4'b0011; w_nb = 3'd2; end
      2'd2:    begin w_lanes = 4'b1111; w_nb = 3'd4; end
      default: begin w_lanes = 4'b1111; w_nb = 3'd4; end
    endcase
    w_mask8 = {4'b0000, w_lanes} << LsuReqAddr[1:0];
    w_last  = {1'b0, LsuReqAddr} + {30'd0, w_nb} - 33'd1;
    w_wd64  = {32'd0, LsuReqWrData} << {LsuReqAddr[1:0], 3'b000};
    w_err   = (LsuReqFunct3[1:0] == 2'd3) || (LsuReqWr && LsuReqFunct3[2]) ||
              (LsuReqAddr < ADDR_LO) || (w_last > {1'b0, ADDR_HI}) ||
              ((w_mask8[7:4] != 4'b0000) && !SPLIT_EN);
  end

  // Merge the arriving read word into its half of the buffer, then align and extend.
  always_comb begin
    w_buf_nxt = r_buf;
    if (r_state == S_WAIT1) begin
      w_buf_nxt = {MemRspData, r_buf[31:0]};
    end else begin
      w_buf_nxt = {r_buf[63:32], MemRspData};
    end
    w_raw     = 32'(w_buf_nxt >> {r_off, 3'b000});
    w_ld_data = ld_extend(w_raw, r_f3);
  end

  // Transaction FSM; every port output is a register written here.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      r_state      <= S_IDLE;
      r_wr         <= 1'b0;
      r_f3         <= 3'd0;
      r_off        <= 2'd0;
      r_split      <= 1'b0;
      r_be_hi      <= 4'd0;
      r_wd_hi      <= 32'd0;
      r_word       <= 32'd0;
      r_buf        <= 64'd0;
      r_cnt        <= '0;
      LsuReqReady  <= 1'b1;
      LsuRspValid  <= 1'b0;
      LsuRspErr    <= 1'b0;
      LsuRspData   <= 32'd0;
      MemReqValid  <= 1'b0;
      MemReqAddr   <= 32'd0;
      MemReqWrEn   <= 1'b0;
      MemReqByteEn <= 4'd0;
      MemReqWrData <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (LsuReqValid) begin
            r_wr        <= LsuReqWr;
            r_f3        <= LsuReqFunct3;
            r_off       <= LsuReqAddr[1:0];
            r_split     <= (w_mask8[7:4] != 4'b0000);
            r_be_hi     <= w_mask8[7:4];
            r_wd_hi     <= w_wd64[63:32];
            r_word      <= {LsuReqAddr[31:2], 2'b00};
            r_buf       <= 64'd0;
            LsuReqReady <= 1'b0;
            if (w_err) begin
              r_state     <= S_RESP;
              LsuRspValid <= 1'b1;
              LsuRspErr   <= 1'b1;
              LsuRspData  <= 32'd0;
            end else begin
              r_state      <= S_REQ0;
              MemReqValid  <= 1'b1;
              MemReqAddr   <= {LsuReqAddr[31:2], 2'b00};
              MemReqWrEn   <= LsuReqWr;
              MemReqByteEn <= w_mask8[3:0];
              MemReqWrData <= w_wd64[31:0];
            end
          end
        end
        S_REQ0: begin
          if (MemReqReady) begin
            if (r_wr && r_split) begin
              r_state      <= S_REQ1;
              MemReqAddr   <= r_word + 32'd4;
              MemReqByteEn <= r_be_hi;
              MemReqWrData <= r_wd_hi;
            end else begin
              MemReqValid  <= 1'b0;
              MemReqAddr   <= 32'd0;
              MemReqWrEn   <= 1'b0;
              MemReqByteEn <= 4'd0;
              MemReqWrData <= 32'd0;
              r_cnt        <= '0;
              if (r_wr) begin
                r_state     <= S_RESP;
                LsuRspValid <= 1'b1;
                LsuRspErr   <= 1'b0;
                LsuRspData  <= 32'd0;
              end else begin
                r_state <= S_WAIT0;
              end
            end
          end
        end
        S_WAIT0, S_WAIT1: begin
          if (MemRspValid) begin
            r_buf <= w_buf_nxt;
            if ((r_state == S_WAIT0) && r_split) begin
              r_state      <= S_REQ1;
              MemReqValid  <= 1'b1;
              MemReqAddr   <= r_word + 32'd4;
              MemReqWrEn   <= 1'b0;
              MemReqByteEn <= r_be_hi;
              MemReqWrData <= r_wd_hi;
            end else begin
              r_state     <= S_RESP;
              LsuRspValid <= 1'b1;
              LsuRspErr   <= 1'b0;
              LsuRspData  <= w_ld_data;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= S_RESP;
            LsuRspValid <= 1'b1;
            LsuRspErr   <= 1'b1;
            LsuRspData  <= 32'd0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_REQ1: begin
          if (MemReqReady) begin
            MemReqValid  <= 1'b0;
            MemReqAddr   <= 32'd0;
            MemReqWrEn   <= 1'b0;
            MemReqByteEn <= 4'd0;
            MemReqWrData <= 32'd0;
            r_cnt        <= '0;
            if (r_wr) begin
              r_state     <= S_RESP;
              LsuRspValid <= 1'b1;
              LsuRspErr   <= 1'b0;
              LsuRspData  <= 32'd0;
            end else begin
              r_state <= S_WAIT1;
            end
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          LsuReqReady <= 1'b1;
          LsuRspValid <= 1'b0;
          LsuRspErr   <= 1'b0;
          LsuRspData  <= 32'd0;
        end
        default: begin
          r_state      <= S_IDLE;
          LsuReqReady  <= 1'b1;
          LsuRspValid  <= 1'b0;
          LsuRspErr    <= 1'b0;
          LsuRspData   <= 32'd0;
          MemReqValid  <= 1'b0;
          MemReqAddr   <= 32'd0;
          MemReqWrEn   <= 1'b0;
          MemReqByteEn <= 4'd0;
          MemReqWrData <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvc_lsu_5pl.sv
// Randomized bench for rvc_lsu_5pl: a byte-level memory/transaction model predicts beats,
// response data, error and latency; a second instance covers the non-splitting build.
module tb_rvc_lsu_5pl;
  localparam int          TO = 16;
  localparam logic [31:0] LO = 32'h0000_1000;
  localparam logic [31:0] HI = 32'h0000_1FFF;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Rst, LsuReqValid, LsuReqReady, LsuReqWr, LsuRspValid, LsuRspErr;
  logic [2:0] LsuReqFunct3;
  logic [31:0] LsuReqAddr, LsuReqWrData, LsuRspData;
  logic MemReqValid, MemReqReady, MemReqWrEn, MemRspValid;
  logic [31:0] MemReqAddr, MemReqWrData, MemRspData;
  logic [3:0] MemReqByteEn;
  logic n_valid, n_ready, n_rspv, n_err, n_mvalid, n_wren;
  logic [31:0] n_data, n_maddr, n_wd;
  logic [3:0] n_be;

  rvc_lsu_5pl #(.ADDR_LO(LO), .ADDR_HI(HI), .SPLIT_EN(1'b1), .RSP_TIMEOUT(TO)) u_dut (
    .Clock(Clock), .Rst(Rst), .LsuReqValid(LsuReqValid), .LsuReqReady(LsuReqReady),
    .LsuReqWr(LsuReqWr), .LsuReqFunct3(LsuReqFunct3), .LsuReqAddr(LsuReqAddr),
    .LsuReqWrData(LsuReqWrData), .LsuRspValid(LsuRspValid), .LsuRspErr(LsuRspErr),
    .LsuRspData(LsuRspData), .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
    .MemReqAddr(MemReqAddr), .MemReqWrEn(MemReqWrEn), .MemReqByteEn(MemReqByteEn),
    .MemReqWrData(MemReqWrData), .MemRspValid(MemRspValid), .MemRspData(MemRspData));

  rvc_lsu_5pl #(.ADDR_LO(LO), .ADDR_HI(HI), .SPLIT_EN(1'b0), .RSP_TIMEOUT(TO)) u_nosplit (
    .Clock(Clock), .Rst(Rst), .LsuReqValid(n_valid), .LsuReqReady(n_ready),
    .LsuReqWr(LsuReqWr), .LsuReqFunct3(LsuReqFunct3), .LsuReqAddr(LsuReqAddr),
    .LsuReqWrData(LsuReqWrData), .LsuRspValid(n_rspv), .LsuRspErr(n_err),
    .LsuRspData(n_data), .MemReqValid(n_mvalid), .MemReqReady(MemReqReady),
    .MemReqAddr(n_maddr), .MemReqWrEn(n_wren), .MemReqByteEn(n_be),
    .MemReqWrData(n_wd), .MemRspValid(MemRspValid), .MemRspData(MemRspData));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sparse memory image: words appear with random contents on first touch.
  bit [31:0] mem [bit [31:0]];

  function automatic bit [31:0] mem_rd(input bit [31:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  function automatic bit [7:0] mem_byte(input bit [31:0] a);
    bit [31:0] w;
    w = mem_rd(a & ~32'h3);
    return 8'(w >> (8 * (a % 4)));
  endfunction

  bit        e_err;
  int        e_n, e_lat;
  bit [31:0] e_data;
  bit [31:0] e_addr [2];
  bit [3:0]  e_be [2];
  bit [31:0] e_wd [2];
  bit [31:0] last_data;

  // Reference: walk the accessed bytes, group them by word, and add up the cycle cost.
  task automatic model(input bit wr, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                       input int rd, input int dly);
    int nb, s;
    bit [32:0] last;
    bit [31:0] word, ba, val;
    bit [3:0] be;
    bit [31:0] wl;
    s = int'(f3[1:0]);
    e_err = 1'b0; e_n = 0; e_data = 32'd0; e_lat = 1;
    nb = (s == 3) ? 4 : (1 << s);
    last = {1'b0, a} + 33'(nb) - 33'd1;
    if (s == 3 || (wr && f3[2]) || a < LO || last > {1'b0, HI}) begin
      e_err = 1'b1;
      return;
    end
    for (int b = 0; b < 2; b++) begin
      word = (a & ~32'h3) + 32'(4 * b);
      be = 4'd0; wl = 32'd0;
      for (int i = 0; i < nb; i++) begin
        ba = a + 32'(i);
        if ((ba & ~32'h3) == word) begin
          be = be | 4'(1 << (ba % 4));
          wl = wl | (32'(wd[8*i +: 8]) << (8 * (ba % 4)));
        end
      end
      if (be != 4'd0) begin
        e_addr[e_n] = word; e_be[e_n] = be; e_wd[e_n] = wl; e_n++;
        e_lat += 1 + rd;
        if (!wr) begin
          if (dly >= TO) begin
            e_lat += TO; e_err = 1'b1;
            return;
          end
          e_lat += 1 + dly;
        end
      end
    end
    if (!wr) begin
      val = 32'd0;
      for (int i = 0; i < nb; i++) val = val | (32'(mem_byte(a + 32'(i))) << (8 * i));
      if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
      e_data = val;
    end
  endtask

  function automatic bit [31:0] be_mask(input bit [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Issue one transaction and act as the memory: Ready after rd cycles, data dly cycles later.
  task automatic run_txn(input bit wr, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                         input int rd, input int dly);
    int k, obs_n, vcnt, rsp_cnt;
    bit hs, done;
    bit [31:0] h_addr, h_wd, last_wa;
    bit [3:0] h_be;
    bit h_wren;
    model(wr, f3, a, wd, rd, dly);
    @(negedge Clock);
    check("req_ready", LsuReqReady, 32'd1);
    LsuReqValid = 1'b1; LsuReqWr = wr; LsuReqFunct3 = f3; LsuReqAddr = a; LsuReqWrData = wd;
    @(negedge Clock);
    LsuReqValid = 1'b0; LsuReqAddr = $urandom; LsuReqWrData = $urandom;
    k = 1; obs_n = 0; vcnt = 0; rsp_cnt = -1; hs = 1'b0; done = 1'b0; last_wa = 32'd0;
    h_addr = 32'd0; h_wd = 32'd0; h_be = 4'd0; h_wren = 1'b0;
    while (!done && k <= 80) begin
      if (hs) begin
        hs = 1'b0; MemReqReady = 1'b0; vcnt = 0;
        if (obs_n < e_n) begin
          check("beat_addr", h_addr, e_addr[obs_n]);
          check("beat_be", 32'(h_be), 32'(e_be[obs_n]));
          check("beat_wren", 32'(h_wren), 32'(wr));
          if (wr) check("beat_wdata", h_wd & be_mask(h_be), e_wd[obs_n]);
        end
        last_wa = h_addr; obs_n++;
        if (!h_wren) rsp_cnt = dly;
      end
      MemRspValid = 1'b0; MemRspData = $urandom;
      if (LsuRspValid) begin
        check("rsp_err", 32'(LsuRspErr), 32'(e_err));
        check("rsp_data", LsuRspData, e_data);
        check("rsp_beats", obs_n, e_n);
        check("rsp_latency", k, e_lat);
        last_data = LsuRspData;
        done = 1'b1;
      end else begin
        if (rsp_cnt == 0) begin
          MemRspValid = 1'b1; MemRspData = mem_rd(last_wa); rsp_cnt = -1;
        end else if (rsp_cnt > 0) begin
          rsp_cnt--;
        end
        if (MemReqValid) begin
          vcnt++;
          if (vcnt > rd) begin
            MemReqReady = 1'b1; hs = 1'b1;
            h_addr = MemReqAddr; h_be = MemReqByteEn; h_wd = MemReqWrData; h_wren = MemReqWrEn;
          end
        end
        @(negedge Clock);
        k++;
      end
    end
    MemRspValid = 1'b0; MemReqReady = 1'b0;
    check("rsp_seen", 32'(done), 32'd1);
  endtask

  initial begin
    bit [2:0] f3;
    bit wr;
    bit [31:0] a;
    int r;
    Rst = 1'b1; LsuReqValid = 1'b0; LsuReqWr = 1'b0; LsuReqFunct3 = 3'd0; LsuReqAddr = 32'd0;
    LsuReqWrData = 32'd0; MemReqReady = 1'b0; MemRspValid = 1'b0; MemRspData = 32'd0;
    n_valid = 1'b0; last_data = 32'd0;
    repeat (3) @(negedge Clock);
    check("rst_ready", LsuReqReady, 32'd1);
    check("rst_mvalid", MemReqValid, 32'd0);
    check("rst_rspv", LsuRspValid, 32'd0);
    check("rst_data", LsuRspData, 32'd0);
    check("rst_maddr", MemReqAddr, 32'd0);
    Rst = 1'b0;

    run_txn(1'b1, 3'b010, 32'h1004, 32'hDEAD_BEEF, 0, 0);
    mem[32'h1000] = 32'h8012_3456;
    run_txn(1'b0, 3'b000, 32'h1003, 32'd0, 0, 0);
    check("lb_sign", last_data, 32'hFFFF_FF80);
    run_txn(1'b0, 3'b100, 32'h1003, 32'd0, 1, 2);
    check("lbu_zero", last_data, 32'h0000_0080);
    mem[32'h1004] = 32'h4433_1122;
    mem[32'h1008] = 32'h9988_6655;
    run_txn(1'b0, 3'b010, 32'h1006, 32'd0, 0, 0);
    check("lw_split", last_data, 32'h6655_4433);
    run_txn(1'b1, 3'b001, 32'h1007, 32'h0000_ABCD, 2, 0);
    run_txn(1'b0, 3'b011, 32'h1000, 32'd0, 0, 0);
    run_txn(1'b0, 3'b010, 32'h0FFC, 32'd0, 0, 0);
    run_txn(1'b0, 3'b010, 32'h1FFE, 32'd0, 0, 0);
    run_txn(1'b1, 3'b100, 32'h1010, 32'h55, 0, 0);
    run_txn(1'b0, 3'b010, 32'h1FFC, 32'd0, 0, TO - 1);
    run_txn(1'b0, 3'b010, 32'h1020, 32'd0, 0, 1000);
    check("to_err", 32'(e_err), 32'd1);
    // A response arriving after the timeout must not produce anything.
    MemRspValid = 1'b1; MemRspData = 32'h1234_5678;
    repeat (2) begin
      @(negedge Clock);
      check("late_rsp_quiet", LsuRspValid, 32'd0);
    end
    MemRspValid = 1'b0;

    // Ready withheld for 5 cycles, then reset while waiting for read data.
    @(negedge Clock);
    LsuReqValid = 1'b1; LsuReqWr = 1'b0; LsuReqFunct3 = 3'b010; LsuReqAddr = 32'h1100;
    @(negedge Clock);
    LsuReqValid = 1'b0;
    repeat (4) begin
      @(negedge Clock);
      check("hold_mvalid", MemReqValid, 32'd1);
      check("hold_maddr", MemReqAddr, 32'h1100);
    end
    MemReqReady = 1'b1;
    @(negedge Clock);
    MemReqReady = 1'b0;
    check("wait_mvalid", MemReqValid, 32'd0);
    @(negedge Clock);
    Rst = 1'b1;
    @(negedge Clock);
    Rst = 1'b0; MemRspValid = 1'b1;
    check("mid_rst_ready", LsuReqReady, 32'd1);
    check("mid_rst_mvalid", MemReqValid, 32'd0);
    check("mid_rst_rspv", LsuRspValid, 32'd0);
    @(negedge Clock);
    MemRspValid = 1'b0;
    check("post_rst_rspv", LsuRspValid, 32'd0);
    run_txn(1'b0, 3'b101, 32'h1006, 32'd0, 1, 1);

    // Non-splitting build: misaligned word errors without memory traffic, aligned store works.
    @(negedge Clock);
    n_valid = 1'b1; LsuReqWr = 1'b0; LsuReqFunct3 = 3'b010; LsuReqAddr = 32'h1001;
    @(negedge Clock);
    n_valid = 1'b0;
    check("ns_rspv", n_rspv, 32'd1);
    check("ns_err", n_err, 32'd1);
    check("ns_mvalid", n_mvalid, 32'd0);
    @(negedge Clock);
    check("ns_ready", n_ready, 32'd1);
    n_valid = 1'b1; LsuReqWr = 1'b1; LsuReqAddr = 32'h1004; LsuReqWrData = 32'hCAFE_F00D;
    MemReqReady = 1'b1;
    @(negedge Clock);
    n_valid = 1'b0;
    check("ns_st_mvalid", n_mvalid, 32'd1);
    check("ns_st_wdata", n_wd, 32'hCAFE_F00D);
    @(negedge Clock);
    MemReqReady = 1'b0;
    check("ns_st_rspv", n_rspv, 32'd1);
    check("ns_st_err", n_err, 32'd0);

    for (int t = 0; t < 150; t++) begin
      r  = int'($urandom % 16);
      wr = 1'($urandom % 2);
      f3[1:0] = (r == 0) ? 2'd3 : 2'($urandom % 3);
      f3[2]   = wr ? (r == 1) : 1'($urandom % 2);
      case ($urandom % 8)
        0:       a = HI - 32'd3 + 32'($urandom % 4);
        1:       a = LO - 32'd4 + 32'($urandom % 8);
        default: a = LO + 32'($urandom % 4096);
      endcase
      run_txn(wr, f3, a, $urandom, int'($urandom % 4),
              ($urandom % 20 == 0) ? 15 + int'($urandom % 3) : int'($urandom % 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
